// File: rtl/arb_pkg.sv
// arb_pkg: shared state encodings and default widths for the DMA/TDSP arbitration slice.
package arb_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF = 8;
  localparam int MAX_BURST_DEF = 16;
  typedef enum logic [2:0] {DMA_IDLE, DMA_REQ, DMA_XFER, DMA_YIELD, DMA_RELEASE} dma_state_t;
  typedef enum logic [1:0] {ARB_TDSP, ARB_DMA, ARB_HANDOFF} arb_state_t;
endpackage

// File: rtl/dma_bus_master_if.sv
// dma_bus_master_if: command, upstream stream, arbiter and memory-write signals of the DMA requester.
interface dma_bus_master_if import arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) ();
  logic cmd_valid, cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic dma_breq, dma_grant;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic busy, done;
  modport master (
    input cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data, dma_grant,
    output cmd_ready, wr_ready, dma_breq, mem_we, mem_addr, mem_wdata, busy, done
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data, dma_grant,
    input cmd_ready, wr_ready, dma_breq, mem_we, mem_addr, mem_wdata, busy, done
  );
endinterface

// File: rtl/dma_addr_len_ctr.sv
// dma_addr_len_ctr: write address up-counter, remaining-word and per-grant burst counters with terminal flags.
module dma_addr_len_ctr import arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic beat,
  input  logic burst_clr,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0] load_len,
  output logic [ADDR_W-1:0] addr,
  output logic rem_last,
  output logic burst_last
);
  logic [LEN_W-1:0] remaining, burst_cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      addr <= '0;
      remaining <= '0;
      burst_cnt <= '0;
    end else if (load) begin
      addr <= load_addr;
      remaining <= load_len;
      burst_cnt <= '0;
    end else begin
      addr <= beat ? addr + 1'b1 : addr;
      remaining <= beat ? remaining - 1'b1 : remaining;
      burst_cnt <= burst_clr ? '0 : beat ? burst_cnt + 1'b1 : burst_cnt;
    end
  assign rem_last = remaining == LEN_W'(1);
  assign burst_last = burst_cnt == LEN_W'(MAX_BURST - 1);
endmodule

// File: rtl/dma_bus_master.sv
// dma_bus_master: requests the shared bus, streams a block of upstream words to memory,
// and yields the bus every MAX_BURST words or at block end.
module dma_bus_master import arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input logic clk,
  input logic reset_n,
  dma_bus_master_if.master bus
);
  dma_state_t state, next;
  logic beat, load, burst_clr, done_set, rem_last, burst_last;
  logic [ADDR_W-1:0] addr;
  dma_addr_len_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)) ctr (
    .clk(clk), .reset_n(reset_n), .load(load), .beat(beat), .burst_clr(burst_clr),
    .load_addr(bus.cmd_addr), .load_len(bus.cmd_len), .addr(addr),
    .rem_last(rem_last), .burst_last(burst_last)
  );
  assign beat = state == DMA_XFER && bus.dma_grant && bus.wr_valid;
  always_comb begin
    next = state;
    load = 1'b0;
    burst_clr = 1'b0;
    done_set = 1'b0;
    case (state)
      DMA_IDLE: if (bus.cmd_valid) begin
        load = bus.cmd_len != '0;
        done_set = bus.cmd_len == '0;
        next = load ? DMA_REQ : DMA_IDLE;
      end
      DMA_REQ: next = bus.dma_grant ? DMA_XFER : DMA_REQ;
      DMA_XFER: if (beat) next = rem_last ? DMA_RELEASE : burst_last ? DMA_YIELD : DMA_XFER;
      DMA_YIELD: if (!bus.dma_grant) begin
        burst_clr = 1'b1;
        next = DMA_REQ;
      end
      DMA_RELEASE: if (!bus.dma_grant) begin
        done_set = 1'b1;
        next = DMA_IDLE;
      end
      default: next = DMA_IDLE;
    endcase
  end
  // request is registered from next state so it never glitches
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= DMA_IDLE;
      bus.dma_breq <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= next;
      bus.dma_breq <= next == DMA_REQ || next == DMA_XFER;
      bus.done <= done_set;
    end
  assign bus.cmd_ready = state == DMA_IDLE;
  assign bus.busy = state != DMA_IDLE;
  assign bus.wr_ready = beat;
  assign bus.mem_we = beat;
  assign bus.mem_addr = addr;
  assign bus.mem_wdata = DATA_W'(bus.wr_data);
endmodule

// File: tb/tb_dma_bus_master.sv
// tb_dma_bus_master: scoreboard bench with an arbiter model of configurable grant latency.
module tb_dma_bus_master;
  localparam int AW = 16, DW = 16, LW = 8, MB = 16;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  dma_bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();
  dma_bus_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  int n_checks = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  logic [15:0] src_q[$];
  int bursts[$];
  int lat = 1, cur = 0, gcnt = 0, writes = 0, dones = 0, cyc = 0, first_w = 0, last_w = 0;
  bit breq_s, breq_seen, toggle, vtog, cmd_pend, chk_breq, prev_breq;
  logic [15:0] cmd_a;
  logic [7:0] cmd_l;

  task automatic start();
    writes = 0; dones = 0; breq_seen = 0; cur = 0; first_w = 0; last_w = 0;
    bursts.delete();
  endtask

  task automatic issue(input logic [15:0] a, input logic [7:0] l);
    for (int i = 0; i < int'(l); i++) begin
      logic [15:0] ea, d;
      ea = a + 16'(i);
      d = 16'($urandom);
      exp_q.push_back({ea, d});
      src_q.push_back(d);
    end
    cmd_a = a; cmd_l = l; cmd_pend = 1'b1;
  endtask

  task automatic cycle();
    logic g;
    logic [31:0] e;
    @(posedge clk); #1;
    cyc++;
    gcnt = breq_s ? gcnt + 1 : 0;
    g = breq_s && gcnt >= lat;
    if (bus.dma_grant && !g) begin bursts.push_back(cur); cur = 0; end
    bus.dma_grant = g;
    vtog = !vtog;
    bus.wr_valid = (toggle ? vtog : 1'b1) && src_q.size() > 0;
    bus.wr_data = src_q.size() > 0 ? src_q[0] : 16'h0;
    bus.cmd_valid = cmd_pend; bus.cmd_addr = cmd_a; bus.cmd_len = cmd_l;
    @(negedge clk);
    if (chk_breq) begin
      chk_breq = 0; n_checks++;
      if (bus.dma_breq !== 1'b0) begin n_fail++; $display("FAIL breq_after_last: got %b want 0", bus.dma_breq); end
    end
    if (bus.dma_breq && !prev_breq) begin
      n_checks++;
      if (bus.dma_grant !== 1'b0) begin n_fail++; $display("FAIL breq_rise_grant: got %b want 0", bus.dma_grant); end
    end
    if (bus.mem_we) begin
      n_checks++;
      if (!(bus.dma_grant && bus.wr_valid && bus.wr_ready)) begin
        n_fail++; $display("FAIL we_qual: grant=%b valid=%b ready=%b want all 1", bus.dma_grant, bus.wr_valid, bus.wr_ready);
      end
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL extra_write: addr=%h data=%h want none", bus.mem_addr, bus.mem_wdata); end
      else begin
        e = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== e) begin
          n_fail++; $display("FAIL write: got addr=%h data=%h want addr=%h data=%h", bus.mem_addr, bus.mem_wdata, e[31:16], e[15:0]);
        end
      end
      if (src_q.size() > 0) void'(src_q.pop_front());
      if (writes == 0) first_w = cyc;
      last_w = cyc; writes++; cur++;
      if (exp_q.size() == 0) chk_breq = 1;
    end
    if (bus.done) begin
      dones++; n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b want 0", bus.busy); end
    end
    if (bus.dma_breq) breq_seen = 1;
    if (cmd_pend && bus.cmd_ready) cmd_pend = 0;
    prev_breq = bus.dma_breq; breq_s = bus.dma_breq;
  endtask

  task automatic run_done(input int budget);
    int n = 0;
    while (dones == 0 && n < budget) begin cycle(); n++; end
    n_checks++;
    if (dones == 0) begin n_fail++; $display("FAIL timeout_done: got no done within %0d cycles", budget); end
    repeat (3) cycle();
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin n_fail++; $display("FAIL %s: got %0d want %0d", name, got, want); end
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    n_checks++;
    if ({bus.cmd_ready, bus.dma_breq, bus.busy, bus.done, bus.mem_we} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_state: got ready,breq,busy,done,we=%b want 10000",
                         {bus.cmd_ready, bus.dma_breq, bus.busy, bus.done, bus.mem_we});
    end
  endtask

  task automatic test_basic();
    start(); lat = 1; toggle = 0;
    issue(16'h0100, 8'd4);
    run_done(50);
    check_int("t1_writes", writes, 4);
    check_int("t1_consecutive", last_w - first_w, 3);
    check_int("t1_done_once", dones, 1);
    check_int("t1_breq_seen", int'(breq_seen), 1);
    check_int("t1_busy", int'(bus.busy), 0);
  endtask

  task automatic test_bursts();
    start(); lat = 2;
    issue(16'h0000, 8'd40);
    run_done(400);
    check_int("t2_writes", writes, 40);
    check_int("t2_grant_periods", bursts.size(), 3);
    if (bursts.size() == 3) begin
      check_int("t2_burst0", bursts[0], 16);
      check_int("t2_burst1", bursts[1], 16);
      check_int("t2_burst2", bursts[2], 8);
    end
    check_int("t2_done_once", dones, 1);
  endtask

  task automatic test_valid_toggle();
    start(); lat = 1; toggle = 1;
    issue(16'h0040, 8'd5);
    run_done(100);
    toggle = 0;
    check_int("t3_writes", writes, 5);
    check_int("t3_exp_left", exp_q.size(), 0);
  endtask

  task automatic test_wrap();
    start();
    issue(16'hFFFE, 8'd4);
    run_done(50);
    check_int("t4_writes", writes, 4);
  endtask

  task automatic test_zero_len();
    start();
    issue(16'h0200, 8'd0);
    run_done(10);
    check_int("t5_breq_seen", int'(breq_seen), 0);
    check_int("t5_writes", writes, 0);
    check_int("t5_done_once", dones, 1);
  endtask

  task automatic test_reset_abort();
    int n = 0;
    start(); lat = 1;
    issue(16'h0300, 8'd8);
    while (writes < 3 && n < 60) begin cycle(); n++; end
    check_int("t6_three_writes", writes, 3);
    @(posedge clk); #1;
    reset_n = 0;
    #1;
    n_checks++;
    if ({bus.dma_breq, bus.mem_we, bus.busy, bus.done} !== 4'b0000) begin
      n_fail++; $display("FAIL t6_abort: got breq,we,busy,done=%b want 0000",
                         {bus.dma_breq, bus.mem_we, bus.busy, bus.done});
    end
    exp_q.delete(); src_q.delete();
    cmd_pend = 0; breq_s = 0; prev_breq = 0; gcnt = 0; chk_breq = 0;
    bus.dma_grant = 0; bus.wr_valid = 0; bus.cmd_valid = 0;
    repeat (2) cycle();
    reset_n = 1;
    repeat (2) cycle();
    check_int("t6_no_done", dones, 0);
    start();
    issue(16'h0500, 8'd3);
    run_done(50);
    check_int("t6_new_writes", writes, 3);
    check_int("t6_exp_left", exp_q.size(), 0);
  endtask

  initial begin
    bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 0; bus.wr_data = '0; bus.dma_grant = 0;
    test_reset();
    test_basic();
    test_bursts();
    test_valid_toggle();
    test_wrap();
    test_zero_len();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
